alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational ALU of the processor between two requesters (port 0: main datapath, port 1: auxiliary unit such as an address/branch helper). It accepts one operation at a time through a valid/ready handshake, latches the operands, drives the ALU from registers, captures the result, and returns it to the granted requester through a second valid/ready handshake. Arbitration is round-robin by default; fixed priority is a compile-time option.

## Interface
- WIDTH, 32, operand/result width; the ALU contract is 32 bits, other values are unsupported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- ReqValid0 / ReqValid1  input  1  requester has an operation pending.
- ReqReady0 / ReqReady1  output  1  operation accepted this cycle.
- ReqOperand1_0 / ReqOperand1_1  input  WIDTH  first operand.
- ReqOperand2_0 / ReqOperand2_1  input  WIDTH  second operand.
- ReqFunc3_0 / ReqFunc3_1  input  3  ALU operation code.
- ReqSubsra0 / ReqSubsra1  input  1  ADD/SUB select.
- RspValid0 / RspValid1  output  1  result available for that requester.
- RspReady0 / RspReady1  input  1  requester takes the result.
- RspResult  output  WIDTH  result, shared by both ports; qualified by RspValid0/1.
- ALUoperand1, ALUoperand2  output  WIDTH  to ALU.
- ALUfunc3  output  3  to ALU.
- ALUsubsra  output  1  to ALU.
- ALUresult  input  WIDTH  from ALU.
- Busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: grant is computed combinationally from ReqValid0/1 and the priority pointer `Last`.
  - One valid: that port is granted.
  - Both valid: the port not equal to `Last` is granted.
  - ReqReady of the granted port is high this cycle; the other ReqReady is low.
  - On the clock edge: latch operands, Func3, Subsra and grant index `Gnt`; go to EXEC.
  - No valid: stay in IDLE with both ReqReady low.
- EXEC: ALU ports are driven from the latched registers, which they mirror in every state. On the edge, `ALUresult` is captured into the RspResult register; go to RESP.
- RESP: RspValid[Gnt] is high and the other RspValid is low.
  - On the edge where RspReady[Gnt] is high: set `Last` <= `Gnt`, go to IDLE.
  - Otherwise hold; RspResult stays stable.
- ReqReady is never high outside IDLE, so requests arriving in EXEC/RESP wait; requesters must hold their valid and data stable until ReqReady.
- Func3 values are forwarded unmodified, including 3'b011. The result for 3'b011 is whatever the ALU produces and is not checked by this block.
- Reset (rst_n low at an edge): state <= IDLE, `Last` <= 1 (port 0 wins the first tie), all latched registers and RspResult <= 0. Any in-flight operation is discarded and no response is issued.

## Timing
- Reset values: ReqReady0/1 = 0 until the first post-reset IDLE cycle with a valid; RspValid0/1 = 0; RspResult = 0; ALUoperand1/2 = 0; ALUfunc3 = 0; ALUsubsra = 0; Busy = 0.
- Accept at cycle N (ReqValid && ReqReady) -> EXEC at N+1 -> RspValid high at N+2.
- Minimum occupancy is 3 cycles per operation when RspReady is high in the first RESP cycle. The next accept is possible at N+3.
- Each cycle RspReady is low in RESP adds one cycle.
- ReqReady has a combinational path from ReqValid0/1; there is no path from RspReady to ReqReady in the same cycle.
- Simultaneous valids on consecutive operations strictly alternate ports, for example 0, 1, 0, 1 after reset.

## Configuration
- ALU_ARB_FIXED_PRIO_EN
  - Defined: port 0 always wins when both are valid; `Last` is not implemented and port 1 can starve.
  - Undefined: round-robin as described above.

## Test plan
- Single op, port 0: ADD 32'h0000_0005 + 32'h0000_0003 (Func3 000, Subsra 0) -> ReqReady0 in cycle N, RspValid0 at N+2 with RspResult = 32'h0000_0008; port 1 signals stay low.
- Port 1 SUB 5 - 7 -> RspResult = 32'hFFFF_FFFE on RspValid1; then port 1 SLL 1 << 4 -> 32'h0000_0010.
- Both valid continuously after reset, four ops, RspReady held high -> grants in order 0, 1, 0, 1 with responses every 3 cycles. With ALU_ARB_FIXED_PRIO_EN defined -> 0, 0, 0, 0.
- Backpressure: RspReady0 held low 5 cycles during RESP of XOR 32'hFF00_FF00 ^ 32'h0F0F_0F0F -> RspResult stable at 32'hF00F_F00F, Busy high, and a port 1 request gets no ReqReady until the cycle after RspReady0 rises.
- Reset mid-operation: rst_n low during EXEC -> next cycle state IDLE, RspValid0/1 = 0, ALU outputs 0. A new port 1 AND 32'hFFFF_0000 & 32'h1234_5678 then returns 32'h1234_0000.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters through valid/ready handshakes.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 always wins); otherwise round-robin.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ReqValid0,
   input  logic             ReqValid1,
   output logic             ReqReady0,
   output logic             ReqReady1,
   input  logic [WIDTH-1:0] ReqOperand1_0,
   input  logic [WIDTH-1:0] ReqOperand1_1,
   input  logic [WIDTH-1:0] ReqOperand2_0,
   input  logic [WIDTH-1:0] ReqOperand2_1,
   input  logic [2:0]       ReqFunc3_0,
   input  logic [2:0]       ReqFunc3_1,
   input  logic             ReqSubsra0,
   input  logic             ReqSubsra1,
   output logic             RspValid0,
   output logic             RspValid1,
   input  logic             RspReady0,
   input  logic             RspReady1,
   output logic [WIDTH-1:0] RspResult,
   output logic [WIDTH-1:0] ALUoperand1,
   output logic [WIDTH-1:0] ALUoperand2,
   output logic [2:0]       ALUfunc3,
   output logic             ALUsubsra,
   input  logic [WIDTH-1:0] ALUresult,
   output logic             Busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_n;
   logic gnt, gnt_n, any, rsp_rdy;
   logic [WIDTH-1:0] op1, op2;
   logic [2:0] f3;
   logic sub;
`ifndef ALU_ARB_FIXED_PRIO_EN
   logic last;
`endif
   assign ALUoperand1 = op1;
   assign ALUoperand2 = op2;
   assign ALUfunc3 = f3;
   assign ALUsubsra = sub;
   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end
   // grant selection, handshakes and next state
   always_comb begin
      any = ReqValid0 | ReqValid1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt_n = ~ReqValid0;
`else
      gnt_n = (ReqValid0 && ReqValid1) ? ~last : ReqValid1;
`endif
      rsp_rdy = gnt ? RspReady1 : RspReady0;
      ReqReady0 = (state == IDLE) && any && !gnt_n;
      ReqReady1 = (state == IDLE) && any && gnt_n;
      RspValid0 = (state == RESP) && !gnt;
      RspValid1 = (state == RESP) && gnt;
      Busy = state != IDLE;
      state_n = (state == IDLE) ? (any ? EXEC : IDLE) :
                (state == EXEC) ? RESP :
                (state == RESP && !rsp_rdy) ? RESP : IDLE;
   end
   // operand latch, result capture and round-robin pointer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gnt <= 1'b0;
         op1 <= '0;
         op2 <= '0;
         f3 <= '0;
         sub <= 1'b0;
         RspResult <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last <= 1'b1;
`endif
      end else begin
         if (state == IDLE && any) begin
            gnt <= gnt_n;
            op1 <= gnt_n ? ReqOperand1_1 : ReqOperand1_0;
            op2 <= gnt_n ? ReqOperand2_1 : ReqOperand2_0;
            f3 <= gnt_n ? ReqFunc3_1 : ReqFunc3_0;
            sub <= gnt_n ? ReqSubsra1 : ReqSubsra0;
         end
         if (state == EXEC) RspResult <= ALUresult;
`ifndef ALU_ARB_FIXED_PRIO_EN
         if (state == RESP && rsp_rdy) last <= gnt;
`endif
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic        s;
   } op_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [1:0] rv = 2'b00, rr = 2'b11;
   op_t rq[2];
   logic ReqReady0, ReqReady1, RspValid0, RspValid1, ALUsubsra, Busy;
   logic [31:0] RspResult, ALUoperand1, ALUoperand2, alu_res;
   logic [2:0] ALUfunc3;
   int n_cmp = 0, n_err = 0, cyc = 0;
   op_t q0[$], q1[$];
   int glog[$], gcyc[$], rport[$], rcyc[$];
   logic [31:0] rres[$];
   bit occ = 1'b0, mlast = 1'b1;
   int age = 0, mg = 0;
   op_t mop = '0;
   logic [31:0] mres = '0;

   function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] f, logic s);
      logic [31:0] r;
      case (f)
         3'd0: r = s ? a - b : a + b;
         3'd1: r = a << b[4:0];
         3'd2: r = {31'b0, $signed(a) < $signed(b)};
         3'd3: r = {31'b0, a < b};
         3'd4: r = a ^ b;
         3'd5: if (s) r = $unsigned($signed(a) >>> b[4:0]); else r = a >> b[4:0];
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   assign alu_res = alu_f(ALUoperand1, ALUoperand2, ALUfunc3, ALUsubsra);

   alu_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .ReqValid0(rv[0]), .ReqValid1(rv[1]),
      .ReqReady0(ReqReady0), .ReqReady1(ReqReady1),
      .ReqOperand1_0(rq[0].a), .ReqOperand1_1(rq[1].a),
      .ReqOperand2_0(rq[0].b), .ReqOperand2_1(rq[1].b),
      .ReqFunc3_0(rq[0].f), .ReqFunc3_1(rq[1].f),
      .ReqSubsra0(rq[0].s), .ReqSubsra1(rq[1].s),
      .RspValid0(RspValid0), .RspValid1(RspValid1),
      .RspReady0(rr[0]), .RspReady1(rr[1]),
      .RspResult(RspResult),
      .ALUoperand1(ALUoperand1), .ALUoperand2(ALUoperand2),
      .ALUfunc3(ALUfunc3), .ALUsubsra(ALUsubsra),
      .ALUresult(alu_res), .Busy(Busy)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic op_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] f, logic s);
      op_t o;
      o.a = a; o.b = b; o.f = f; o.s = s;
      return o;
   endfunction

   task automatic feed();
      if (!rv[0] && q0.size() != 0) begin rq[0] = q0.pop_front(); rv[0] = 1'b1; end
      if (!rv[1] && q1.size() != 0) begin rq[1] = q1.pop_front(); rv[1] = 1'b1; end
   endtask

   // one clock: drive, check at negedge against the model, advance the model at posedge
   task automatic step();
      bit acc, s0, s1;
      int g;
      feed();
      @(negedge clk);
      g = (rv[0] && rv[1]) ? (FIXED ? 0 : (mlast ? 0 : 1)) : (rv[1] ? 1 : 0);
      acc = !occ && (rv != 2'b00);
      chk("ReqReady0", ReqReady0, acc && g == 0);
      chk("ReqReady1", ReqReady1, acc && g == 1);
      chk("RspValid0", RspValid0, occ && age >= 1 && mg == 0);
      chk("RspValid1", RspValid1, occ && age >= 1 && mg == 1);
      chk("Busy", Busy, occ);
      chk("RspResult", RspResult, mres);
      chk("ALUoperand1", ALUoperand1, mop.a);
      chk("ALUoperand2", ALUoperand2, mop.b);
      chk("ALUfunc3", ALUfunc3, mop.f);
      chk("ALUsubsra", ALUsubsra, mop.s);
      s0 = rst_n && ReqReady0;
      s1 = rst_n && ReqReady1;
      if (s0) begin glog.push_back(0); gcyc.push_back(cyc); end
      if (s1) begin glog.push_back(1); gcyc.push_back(cyc); end
      if (rst_n && RspValid0 && rr[0]) begin rport.push_back(0); rres.push_back(RspResult); rcyc.push_back(cyc); end
      if (rst_n && RspValid1 && rr[1]) begin rport.push_back(1); rres.push_back(RspResult); rcyc.push_back(cyc); end
      @(posedge clk);
      if (!rst_n) begin
         occ = 1'b0; mlast = 1'b1; mop = '0; mres = '0;
      end else if (!occ) begin
         if (acc) begin occ = 1'b1; age = 0; mg = g; mop = rq[g]; end
      end else if (age == 0) begin
         mres = alu_f(mop.a, mop.b, mop.f, mop.s);
         age = 1;
      end else if (rr[mg]) begin
         occ = 1'b0;
         mlast = (mg == 1);
      end
      #1;
      if (s0) rv[0] = 1'b0;
      if (s1) rv[1] = 1'b0;
      cyc++;
   endtask

   task automatic drain();
      int n = 0;
      rr = 2'b11;
      while ((q0.size() != 0 || q1.size() != 0 || rv != 2'b00 || occ) && n < 200) begin
         step();
         n++;
      end
      chk("drain_bound", n < 200, 1);
   endtask

   initial begin
      int gb, rb, nr, ng;
      rq[0] = '0;
      rq[1] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      // single ADD on port 0
      q0.push_back(mk(32'd5, 32'd3, 3'b000, 1'b0));
      drain();
      chk("add_port", rport[$], 0);
      chk("add_res", rres[$], 32'h0000_0008);
      chk("add_lat", rcyc[$] - gcyc[$], 2);
      // SUB then SLL on port 1
      q1.push_back(mk(32'd5, 32'd7, 3'b000, 1'b1));
      q1.push_back(mk(32'd1, 32'd4, 3'b001, 1'b0));
      drain();
      chk("sub_res", rres[$-1], 32'hFFFF_FFFE);
      chk("sub_port", rport[$-1], 1);
      chk("sll_res", rres[$], 32'h0000_0010);
      // both valid continuously after reset
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      gb = glog.size();
      rb = rcyc.size();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk($urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1))));
         q1.push_back(mk($urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1))));
      end
      drain();
      for (int i = 0; i < 4; i++) chk("rr_order", glog[gb + i], FIXED ? 0 : i % 2);
      for (int i = 1; i < 4; i++) chk("rr_spacing", rcyc[rb + i] - rcyc[rb + i - 1], 3);
      // backpressure on port 0 while port 1 waits
      rr = 2'b10;
      q0.push_back(mk(32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100, 1'b0));
      repeat (3) step();
      q1.push_back(mk(32'hA5A5_0000, 32'h0000_5A5A, 3'b110, 1'b0));
      repeat (4) step();
      rr = 2'b11;
      step();
      step();
      chk("bp_res", rres[$], 32'hF00F_F00F);
      chk("bp_port", rport[$], 0);
      chk("bp_grant_port", glog[$], 1);
      chk("bp_grant_cyc", gcyc[$] - rcyc[$], 1);
      drain();
      // reset during EXEC discards the operation
      nr = rport.size();
      q0.push_back(mk(32'd9, 32'd9, 3'b000, 1'b0));
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      step();
      chk("rst_no_rsp", rport.size(), nr);
      q1.push_back(mk(32'hFFFF_0000, 32'h1234_5678, 3'b111, 1'b0));
      drain();
      chk("and_port", rport[$], 1);
      chk("and_res", rres[$], 32'h1234_0000);
      // randomized traffic with random backpressure
      nr = rport.size();
      ng = glog.size();
      for (int t = 0; t < 400; t++) begin
         if (q0.size() < 2 && $urandom_range(2) == 0)
            q0.push_back(mk($urandom, $urandom_range(1) ? $urandom : 32'($urandom_range(40)), 3'($urandom_range(7)), 1'($urandom_range(1))));
         if (q1.size() < 2 && $urandom_range(2) == 0)
            q1.push_back(mk($urandom, $urandom_range(1) ? $urandom : 32'($urandom_range(40)), 3'($urandom_range(7)), 1'($urandom_range(1))));
         rr[0] = $urandom_range(3) != 0;
         rr[1] = $urandom_range(3) != 0;
         step();
      end
      drain();
      chk("rand_rsp_count", rport.size() - nr, glog.size() - ng);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
